zxuno_regbus_arbiter: RTL

- Owns the ZX-Uno internal register bus (zxuno_addr / zxuno_regrd / zxuno_regwr plus data), which feeds every register peripheral.
- Shares the bus between two requesters: the CPU, through I/O ports FC3B (address) and FD3B (data), and one auxiliary master such as a config loader.
- Sequences fixed-length read and write strobes, captures read data, and stalls the CPU with WAIT while the auxiliary master holds the bus.

---
 rtl/zxuno_regbus_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/zxuno_regbus_arbiter.sv
// zxuno_regbus_arbiter: shares the ZX-Uno register bus between CPU ports FC3B/FD3B and an aux master; `REGBUS_AUTOINC_EN` enables CPU address auto-increment
module zxuno_regbus_arbiter #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B,
  parameter int RD_WAIT = 2
) (
  input  logic        clk,
  input  logic        poweron_rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe_n,
  output logic        cpu_wait_n,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [7:0]  aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic        aux_gnt,
  output logic        aux_done,
  output logic [7:0]  aux_rdata,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_oe_n
);
`ifdef REGBUS_AUTOINC_EN
  localparam logic [7:0] INC = 8'd1;
`else
  localparam logic [7:0] INC = 8'd0;
`endif
  typedef enum logic [2:0] {IDLE, CPU_WR, CPU_RD, CPU_HOLD, AUX_WR, AUX_RD, AUX_DONE} state_t;
  state_t state;
  logic [7:0] addr_reg, wdata_lat, dout_reg, wdata_n, rd_val;
  logic [2:0] cnt;
  logic prev_rd_n, prev_wr_n, pend_rd, pend_wr, aux_block;
  logic io_rd, io_wr, at_addr, at_data, det_rd, det_wr, addr_wr, want_rd, want_wr, last_rd, hold_end;
  always_comb begin
    io_rd = !iorq_n && !rd_n;
    io_wr = !iorq_n && !wr_n;
    at_addr = a == ADDR_PORT;
    at_data = a == DATA_PORT;
    det_rd = io_rd && prev_rd_n && at_data;
    det_wr = io_wr && prev_wr_n && at_data;
    addr_wr = io_wr && prev_wr_n && at_addr;
    want_rd = pend_rd || det_rd;
    want_wr = pend_wr || det_wr;
    wdata_n = det_wr ? cpu_din : wdata_lat;
    rd_val = bus_oe_n ? 8'hFF : bus_rdata;
    last_rd = cnt == 3'(RD_WAIT - 1);
    hold_end = state == CPU_HOLD && !io_rd;
    cpu_oe_n = !(io_rd && (at_addr || (at_data && state == CPU_HOLD)));
    cpu_dout = (io_rd && at_addr) ? addr_reg : dout_reg;
    cpu_wait_n = !(at_data && (io_rd || io_wr) && (want_rd || want_wr || state == CPU_WR || state == CPU_RD));
  end
  // edge detectors follow the pins even in reset so an access in flight at release is never replayed
  always_ff @(posedge clk) begin
    prev_rd_n <= iorq_n | rd_n;
    prev_wr_n <= iorq_n | wr_n;
    if (!poweron_rst_n) begin
      state <= IDLE;
      addr_reg <= 8'h00;
      zxuno_addr <= 8'h00;
      zxuno_regrd <= 1'b0;
      zxuno_regwr <= 1'b0;
      bus_wdata <= 8'h00;
      dout_reg <= 8'hFF;
      aux_gnt <= 1'b0;
      aux_done <= 1'b0;
      aux_rdata <= 8'h00;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
      wdata_lat <= 8'h00;
      cnt <= 3'd0;
      aux_block <= 1'b0;
    end else begin
      addr_reg <= addr_wr ? cpu_din : (state == CPU_WR || hold_end) ? addr_reg + INC : addr_reg;
      wdata_lat <= wdata_n;
      pend_wr <= want_wr && state != IDLE;
      pend_rd <= want_rd && !(state == IDLE && !want_wr);
      aux_done <= 1'b0;
      case (state)
        IDLE: begin
          aux_block <= 1'b0;
          cnt <= 3'd0;
          if (want_wr) begin
            state <= CPU_WR;
            zxuno_regwr <= 1'b1;
            zxuno_addr <= addr_reg;
            bus_wdata <= wdata_n;
          end else if (want_rd) begin
            state <= CPU_RD;
            zxuno_regrd <= 1'b1;
            zxuno_addr <= addr_reg;
          end else if (aux_req && !aux_block) begin
            state <= aux_we ? AUX_WR : AUX_RD;
            aux_gnt <= 1'b1;
            zxuno_addr <= aux_addr;
            bus_wdata <= aux_we ? aux_wdata : bus_wdata;
            zxuno_regwr <= aux_we;
            zxuno_regrd <= !aux_we;
          end
        end
        CPU_WR: begin
          zxuno_regwr <= 1'b0;
          state <= IDLE;
        end
        CPU_RD, AUX_RD: begin
          cnt <= cnt + 3'd1;
          if (last_rd) begin
            zxuno_regrd <= 1'b0;
            if (state == CPU_RD) begin
              dout_reg <= rd_val;
              state <= CPU_HOLD;
            end else begin
              aux_rdata <= rd_val;
              aux_gnt <= 1'b0;
              aux_done <= 1'b1;
              state <= AUX_DONE;
            end
          end
        end
        CPU_HOLD: state <= io_rd ? CPU_HOLD : IDLE;
        AUX_WR: begin
          zxuno_regwr <= 1'b0;
          aux_gnt <= 1'b0;
          aux_done <= 1'b1;
          state <= AUX_DONE;
        end
        AUX_DONE: begin
          aux_block <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
